// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit and owner of the HI/LO registers.
// mult/div hold busy for MULT_CYCLES/DIV_CYCLES, then commit; mthi/mtlo commit in one cycle.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] hilo_out
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_N + 1);
   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [2:0]       r_op;

   logic             w_accept_long;
   logic             w_commit;
   logic             w_wr_mthi;
   logic             w_wr_mtlo;

   // Next-state and control: start is only looked at while idle, so a start
   // arriving during busy has no effect at all.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_accept_long = 1'b0;
      w_commit      = 1'b0;
      w_wr_mthi     = 1'b0;
      w_wr_mtlo     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (md_op)
                  OP_MULT, OP_MULTU: begin
                     w_accept_long = 1'b1;
                     w_cnt_nxt     = MULT_N;
                     w_state_nxt   = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     w_accept_long = 1'b1;
                     w_cnt_nxt     = DIV_N;
                     w_state_nxt   = S_BUSY;
                  end
                  OP_MTHI: w_wr_mthi = 1'b1;
                  OP_MTLO: w_wr_mtlo = 1'b1;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Arithmetic on the latched operands; divisor is forced nonzero so the
   // divide-by-zero path never evaluates an undefined quotient.
   logic [63:0]        w_a_sx;
   logic [63:0]        w_b_sx;
   logic [63:0]        w_prod_s;
   logic [63:0]        w_prod_u;
   logic [31:0]        w_udivisor;
   logic signed [31:0] w_sdividend;
   logic signed [31:0] w_sdivisor;
   logic signed [31:0] w_squo;
   logic signed [31:0] w_srem;
   logic [31:0]        w_uquo;
   logic [31:0]        w_urem;
   logic               w_b_zero;
   logic               w_sdiv_ovf;
   logic [63:0]        w_res;
   logic               w_res_vld;

   assign w_a_sx      = {{32{r_a[31]}}, r_a};
   assign w_b_sx      = {{32{r_b[31]}}, r_b};
   assign w_prod_s    = w_a_sx * w_b_sx;
   assign w_prod_u    = {32'd0, r_a} * {32'd0, r_b};
   assign w_b_zero    = (r_b == 32'd0);
   assign w_udivisor  = w_b_zero ? 32'd1 : r_b;
   assign w_sdividend = $signed(r_a);
   assign w_sdivisor  = $signed(w_udivisor);
   assign w_squo      = w_sdividend / w_sdivisor;
   assign w_srem      = w_sdividend % w_sdivisor;
   assign w_uquo      = r_a / w_udivisor;
   assign w_urem      = r_a % w_udivisor;
   assign w_sdiv_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);

   always_comb begin
      w_res     = 64'd0;
      w_res_vld = 1'b1;
      case (r_op)
         OP_MULT:  w_res = w_prod_s;
         OP_MULTU: w_res = w_prod_u;
         OP_DIV: begin
            if (w_b_zero)        w_res_vld = 1'b0;
            else if (w_sdiv_ovf) w_res     = {32'd0, 32'h8000_0000};
            else                 w_res     = {w_srem, w_squo};
         end
         OP_DIVU: begin
            if (w_b_zero) w_res_vld = 1'b0;
            else          w_res     = {w_urem, w_uquo};
         end
         default: w_res_vld = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept_long) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= md_op;
         end
         if (w_wr_mthi) r_hi <= a;
         if (w_wr_mtlo) r_lo <= a;
         if (w_commit && w_res_vld) begin
            r_hi <= w_res[63:32];
            r_lo <= w_res[31:0];
         end
      end
   end

   assign busy     = (r_state == S_BUSY);
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign hilo_out = rd_sel ? r_hi : r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
EX-stage multiply/divide unit and owner of the HI/LO architectural registers. It is the producer side of the HILO datapath: its hilo_out feeds the EX/MEM pipeline register's HILO field.
- Runs multi-cycle mult/multu/div/divu.
- Signals busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo in D.
- Services mthi/mtlo in a single cycle.

Parameters:
MULT_CYCLES, 5, busy duration of mult/multu in cycles (must be >= 1)
DIV_CYCLES, 10, busy duration of div/divu in cycles (must be >= 1)

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high
start  in  1  E-stage op valid this cycle; single-cycle pulse per instruction
md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a  in  32  forwarded rs value
b  in  32  forwarded rt value
rd_sel  in  1  0 selects LO, 1 selects HI for hilo_out
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register
hilo_out  out  32  rd_sel ? hi : lo; combinational from the current registers

Behaviour:
Reset (posedge clk with reset=1):
- hi=0, lo=0, busy=0; internal counter and operand latches cleared.
- Reset overrides start in the same cycle.
- Reset mid-operation aborts the op; its result is never written.

Accept rule: an op is accepted when start=1, busy=0 and md_op is in 1..6 at a posedge. start while busy=1 is ignored entirely (no state change). The hazard unit guarantees this never happens; the unit must still be robust to it.

mthi/mtlo (accepted in cycle T):
- hi<=a (or lo<=a) at the end of T.
- busy stays 0; the new value is visible in cycle T+1.

mult/multu/div/divu (accepted in cycle T):
- a, b and the op are latched at the end of T.
- Counter is loaded with N = MULT_CYCLES or DIV_CYCLES; busy=1 in cycles T+1..T+N.
- The counter decrements each cycle.
- At the end of cycle T+N, {hi,lo} are written and busy falls. Results are visible and busy=0 in cycle T+N+1.
- A new start is accepted in T+N+1 at the earliest (back-to-back with one gap-free cycle).

Arithmetic:
- mult: 64-bit signed product of a and b; hi=[63:32], lo=[31:0].
- multu: 64-bit unsigned product.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
- div with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div or divu, b=0): busy runs the full DIV_CYCLES, then hi/lo are left unchanged.
- The result may be computed combinationally from the latched operands; only the timing above is architectural.

hilo_out / hi / lo:
- Never show in-flight results; they reflect committed registers only.
- mfhi/mflo are stalled by the hazard unit while busy.

Test Plan:
- Reset, then mult a=0xFFFFFFFD (-3), b=5 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0. hilo_out is 0 throughout busy.
- multu a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. A second multu started the cycle after busy falls is accepted.
- div cases, each with busy=10 cycles:
  - a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu 7/0 -> hi/lo keep their prior values.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> busy stays 0. hi is updated the next cycle, lo the cycle after. rd_sel toggles hilo_out between the two.
- Start div a=100, b=7. Pulse start with mthi a=0xDEAD at busy cycle 3 -> the mthi is ignored; final hi=2, lo=14.
- Start div, assert reset at busy cycle 4 -> next cycle busy=0, hi=0, lo=0. No late write after the original completion time.
